// File: rtl/div_wb_pkg.sv
// Shared types and constants for the divider writeback sequencer.
// Used by div_req_fifo and div_writeback_seq. Optional feature macro: DIVWB_DZ_TRAP_EN.
package div_wb_pkg;

  // Default datapath widths. The top-level parameters DATA_W and REG_AW
  // must keep these values, because the request struct below uses them.
  localparam int DW = 8;
  localparam int AW = 3;

  // The combinational divider returns this value for both the quotient and
  // the remainder when the divisor is zero.
  localparam logic [DW-1:0] DZ_VALUE = 8'hFF;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB_Q = 2'd2,
    WB_R = 2'd3
  } div_state_e;

  // One buffered divide request, as it is stored in the FIFO.
  typedef struct packed {
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_r;
  } div_req_t;

  localparam int REQ_W = $bits(div_req_t);

endpackage

// File: rtl/div_req_fifo.sv
// Small synchronous request FIFO with push, pop and an occupancy count.
// Pointers wrap modulo DEPTH, which must be a power of two and at least 2.
// Pointers and count reset asynchronously (active low). Storage is not reset.
module div_req_fifo #(
  parameter  int WIDTH = 22,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO or a pop from an empty one is ignored.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointer and count values. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write. The pointer reset is enough to make the stored contents irrelevant.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/div_writeback_seq.sv
// Sequencer around the combinational 8-bit divider.
// It buffers requests, drives registered operands, captures the results, and
// then writes the quotient and the remainder through one shared write port.
// Optional feature macro: DIVWB_DZ_TRAP_EN. When it is defined, a zero divisor
// skips both writebacks and pulses dz_trap instead.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready.
// req_ready depends only on the FIFO occupancy. A write transfers on a rising
// edge where wb_en && wb_ready. While wb_en is high and wb_ready is low,
// wb_addr and wb_data hold steady.
module div_writeback_seq
  import div_wb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_dividend,
  input  logic [DATA_W-1:0] req_divisor,
  input  logic [REG_AW-1:0] req_rd_q,
  input  logic [REG_AW-1:0] req_rd_r,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic              dz_flag
`ifdef DIVWB_DZ_TRAP_EN
  ,
  output logic              dz_trap
`endif
);

  localparam int CNT_W   = $clog2(QDEPTH) + 1;
  localparam int ENTRY_W = 2 * DATA_W + 2 * REG_AW;

  div_state_e        state_q, state_d;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] head_bits;
  div_req_t          push_req;
  div_req_t          head_req;

  logic [DATA_W-1:0] op_dividend_q;
  logic [DATA_W-1:0] op_divisor_q;
  logic [REG_AW-1:0] dst_quo_q;
  logic [REG_AW-1:0] dst_rem_q;
  logic [DATA_W-1:0] res_quo_q;
  logic [DATA_W-1:0] res_rem_q;
  logic              dz_flag_q;
  logic              div_by_zero;

  // Pack the incoming request into the FIFO entry layout.
  always_comb begin
    push_req          = '0;
    push_req.dividend = req_dividend;
    push_req.divisor  = req_divisor;
    push_req.rd_q     = req_rd_q;
    push_req.rd_r     = req_rd_r;
  end

  assign fifo_push = req_valid && !fifo_full;
  assign req_ready = !fifo_full;
  assign head_req  = head_bits;

  div_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (push_req),
    .pop_i   (fifo_pop),
    .data_o  (head_bits),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The divisor register feeds the divider directly, so this flag is valid throughout EXEC.
  assign div_by_zero = (op_divisor_q == '0);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state. WB_R is entered only when a remainder destination is given.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = EXEC;
`ifdef DIVWB_DZ_TRAP_EN
      EXEC: state_d = div_by_zero ? IDLE : WB_Q;
`else
      EXEC: state_d = WB_Q;
`endif
      WB_Q: if (wb_ready) state_d = (dst_rem_q != '0) ? WB_R : IDLE;
      WB_R: if (wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. The write port and the FIFO pop are decoded from the current state only.
  always_comb begin
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: fifo_pop = !fifo_empty;
      WB_Q: begin
        wb_en   = 1'b1;
        wb_addr = dst_quo_q;
        wb_data = res_quo_q;
      end
      WB_R: begin
        wb_en   = 1'b1;
        wb_addr = dst_rem_q;
        wb_data = res_rem_q;
      end
      default: ;
    endcase
  end

  // Operand and destination capture on pop.
  // Result capture at the end of EXEC, after the divider has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_dividend_q <= '0;
      op_divisor_q  <= '0;
      dst_quo_q     <= '0;
      dst_rem_q     <= '0;
      res_quo_q     <= '0;
      res_rem_q     <= '0;
    end else begin
      if (fifo_pop) begin
        op_dividend_q <= head_req.dividend;
        op_divisor_q  <= head_req.divisor;
        dst_quo_q     <= head_req.rd_q;
        dst_rem_q     <= head_req.rd_r;
      end
      if (state_q == EXEC) begin
        res_quo_q <= div_quotient;
        res_rem_q <= div_remainder;
      end
    end
  end

  // Sticky divide-by-zero flag. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              dz_flag_q <= 1'b0;
    else if (state_q == EXEC && div_by_zero) dz_flag_q <= 1'b1;
  end

`ifdef DIVWB_DZ_TRAP_EN
  logic dz_trap_q;

  // One-cycle trap pulse in the cycle after an EXEC with a zero divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dz_trap_q <= 1'b0;
    else        dz_trap_q <= (state_q == EXEC) && div_by_zero;
  end

  assign dz_trap = dz_trap_q;
`endif

  assign div_dividend = op_dividend_q;
  assign div_divisor  = op_divisor_q;
  assign dz_flag      = dz_flag_q;
  assign busy         = (state_q != IDLE) || (fifo_count != '0);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_div_writeback_seq.sv
// Self-checking bench for div_writeback_seq.
// It models the external combinational divider. Expected writebacks come from
// plain division arithmetic and are compared in order against the write port.
`timescale 1ns/1ps
module tb_div_writeback_seq;
  import div_wb_pkg::*;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int QDEPTH = 2;
  localparam int W      = REG_AW + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_dividend = '0;
  logic [DATA_W-1:0] req_divisor = '0;
  logic [REG_AW-1:0] req_rd_q = '0;
  logic [REG_AW-1:0] req_rd_r = '0;
  logic [DATA_W-1:0] div_dividend;
  logic [DATA_W-1:0] div_divisor;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              busy;
  logic [1:0]        dbg_state;
  logic              dz_flag;
`ifdef DIVWB_DZ_TRAP_EN
  logic              dz_trap;
`endif

  logic              dir_ready = 1'b1;
  logic              rnd_ready = 1'b1;
  logic              rand_mode = 1'b0;
  logic              exp_dz = 1'b0;
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] rf[8];
  int                checks = 0;
  int                errors = 0;

  // Clock and reference divider.
  always #5 clk = ~clk;
  assign div_quotient  = (div_divisor == '0) ? DZ_VALUE : div_dividend / div_divisor;
  assign div_remainder = (div_divisor == '0) ? DZ_VALUE : div_dividend % div_divisor;
  assign wb_ready      = rand_mode ? rnd_ready : dir_ready;

  div_writeback_seq #(.DATA_W(DATA_W), .REG_AW(REG_AW), .QDEPTH(QDEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_rd_q      (req_rd_q),
    .req_rd_r      (req_rd_r),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_ready      (wb_ready),
    .busy          (busy),
    .dbg_state     (dbg_state),
    .dz_flag       (dz_flag)
`ifdef DIVWB_DZ_TRAP_EN
    ,
    .dz_trap       (dz_trap)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue the writes a request should produce.
  task automatic model_push(input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] rq, input logic [2:0] rr);
    logic [7:0] q;
    logic [7:0] r;
    q = (b == 0) ? DZ_VALUE : a / b;
    r = (b == 0) ? DZ_VALUE : a % b;
    if (b == 0) exp_dz = 1'b1;
`ifdef DIVWB_DZ_TRAP_EN
    if (b == 0) return;
`endif
    exp_q.push_back({rq, q});
    if (rr != 0) exp_q.push_back({rr, r});
  endtask

  // Driver: wait for ready (bounded), present the request for one edge, then record it.
  task automatic push_req(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] rq, input logic [2:0] rr);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_ready_wait", req_ready, 1);
    req_valid = 1'b1; req_dividend = a; req_divisor = b; req_rd_q = rq; req_rd_r = rr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_push(a, b, rq, rr);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Random wb_ready source, updated away from the sampling edge.
  always @(posedge clk) begin
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard: every accepted write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && wb_en && wb_ready) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 'x;
      check("wb_write", {wb_addr, wb_data}, e);
      rf[wb_addr] = wb_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #12;
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_div_dividend", div_dividend, 0);
    check("rst_div_divisor", div_divisor, 0);
    check("rst_dz_flag", dz_flag, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", req_ready, 1);

    // 100/7 to r1/r2: latency and order.
    dir_ready = 1'b1;
    push_req(8'd100, 8'd7, 3'd1, 3'd2);
    check("t1_no_wb_T", wb_en, 0);
    @(posedge clk); #1;
    check("t1_op_dividend", div_dividend, 100);
    check("t1_op_divisor", div_divisor, 7);
    check("t1_no_wb_exec", wb_en, 0);
    check("t1_busy", busy, 1);
    @(posedge clk); #1;
    check("t1_q_en", wb_en, 1);
    check("t1_q_addr", wb_addr, 1);
    check("t1_q_data", wb_data, 14);
    @(posedge clk); #1;
    check("t1_r_en", wb_en, 1);
    check("t1_r_addr", wb_addr, 2);
    check("t1_r_data", wb_data, 2);
    @(posedge clk); #1;
    check("t1_done_en", wb_en, 0);
    check("t1_done_busy", busy, 0);
    check("t1_dz", dz_flag, 0);

    // 200/0: divide by zero.
    push_req(8'd200, 8'd0, 3'd3, 3'd4);
    wait_idle("t2");
    check("t2_dz_set", dz_flag, 1);

    // 50/5 to r5, no remainder, writeback stalled for 3 cycles.
    dir_ready = 1'b0;
    push_req(8'd50, 8'd5, 3'd5, 3'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_en", wb_en, 1);
      check("t3_hold_addr", wb_addr, 5);
      check("t3_hold_data", wb_data, 10);
      if (i == 3) dir_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("t3_no_rem", wb_en, 0);
    wait_idle("t3");

    // Three back-to-back requests against a stalled write port.
    dir_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_req(8'($urandom_range(0, 255)), 8'($urandom_range(1, 20)),
               3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)));
    check("t4_full_ready", req_ready, 0);
    check("t4_busy", busy, 1);
    dir_ready = 1'b1;
    wait_idle("t4");

    // Random traffic with random write back-pressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 24; i++)
      push_req(8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    wait_idle("t5");
    rand_mode = 1'b0;
    check("t5_dz", dz_flag, exp_dz);

    // Same destination: the remainder lands last.
    push_req(8'd17, 8'd3, 3'd6, 3'd6);
    wait_idle("t6");
    check("t6_rf6", rf[6], 2);

    // Asynchronous reset in the middle of a stalled quotient write.
    dir_ready = 1'b0;
    push_req(8'd9, 8'd2, 3'd1, 3'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t7_in_wbq", wb_en, 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_wb_en", wb_en, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_dz", dz_flag, 0);
    check("t7_rst_dividend", div_dividend, 0);
    exp_q.delete();
    exp_dz = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("t7_ready", req_ready, 1);
    dir_ready = 1'b1;
    push_req(8'd9, 8'd2, 3'd1, 3'd2);
    wait_idle("t7");
    check("t7_rf1", rf[1], 4);
    check("t7_rf2", rf[2], 1);
    check("t7_dz", dz_flag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
